// File: rtl/sophialicmu_math_pkg.sv
// Shared types and constants for the sophialiCMU_math loader.
// SOPHIALI_LOADER_CLEAR_EN prepends two zeroing shifts to every load.
package sophialicmu_math_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        XOR = 2'b10,
        LSH = 2'b11
    } arith_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        CHECK,
        DONE
    } loader_state_t;

    // One request presented to the math unit's en/in/arithOp pins.
    typedef struct packed {
        logic      en;
        logic [2:0] operand;
        arith_op_t op;
    } math_req_t;

    localparam int STEP_W = 3;

`ifdef SOPHIALI_LOADER_CLEAR_EN
    localparam int CLEAR_STEPS = 2;
`else
    localparam int CLEAR_STEPS = 0;
`endif

    localparam int NSTEPS = CLEAR_STEPS + 5;

endpackage

// File: rtl/sophialicmu_loader_step_rom.sv
// Maps a load step and latched target to the (op, operand) pair issued to the math unit.
// SOPHIALI_LOADER_CLEAR_EN adds the two leading shift-out steps.
module sophialicmu_loader_step_rom
    import sophialicmu_math_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    input  logic [7:0]        target,
    output arith_op_t         op,
    output logic [2:0]        operand
);

    logic [STEP_W-1:0] idx;

    always_comb begin
        op      = ADD;
        operand = '0;
        idx     = step - STEP_W'(CLEAR_STEPS);
`ifdef SOPHIALI_LOADER_CLEAR_EN
        // Shift by 7 then 1 flushes any 8-bit accumulator to zero.
        if (step < STEP_W'(CLEAR_STEPS)) begin
            op      = LSH;
            operand = (step == '0) ? 3'd7 : 3'd1;
        end else
`endif
        case (idx)
            3'd0: begin op = ADD; operand = target[7:5];         end
            3'd1: begin op = LSH; operand = 3'd3;                end
            3'd2: begin op = XOR; operand = target[4:2];         end
            3'd3: begin op = LSH; operand = 3'd2;                end
            3'd4: begin op = XOR; operand = {1'b0, target[1:0]}; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sophialicmu_math_loader.sv
// Load sequencer and manual/loader arbiter in front of the sophialiCMU_math accumulator.
// Build with SOPHIALI_LOADER_CLEAR_EN to zero the accumulator before each load.
module sophialicmu_math_loader
    import sophialicmu_math_pkg::*;
#(
    parameter int EN_HIGH_CYCLES = 1,
    parameter int EN_LOW_CYCLES  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] target,
    input  logic       man_en,
    input  logic [2:0] man_in,
    input  logic [1:0] man_op,
    input  logic [7:0] math_out,
    output logic       math_en,
    output logic [2:0] math_in,
    output logic [1:0] math_op,
    output logic       busy,
    output logic       done,
    output logic       match
);

    loader_state_t     state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [15:0]       dwell, dwell_nxt;
    logic [7:0]        target_q;
    logic              match_q;
    arith_op_t         rom_op;
    logic [2:0]        rom_operand;
    math_req_t         man_req, ldr_req, out_req;

    sophialicmu_loader_step_rom u_rom (
        .step    (step),
        .target  (target_q),
        .op      (rom_op),
        .operand (rom_operand)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            dwell    <= '0;
            target_q <= '0;
            match_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            dwell <= dwell_nxt;
            if (state == IDLE && start) begin
                target_q <= target;
                match_q  <= 1'b0;
            end
            if (state == CHECK)
                match_q <= (math_out == target_q);
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        dwell_nxt = dwell;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    step_nxt  = '0;
                    dwell_nxt = '0;
                end
            end
            ISSUE: begin
                if (dwell == 16'(EN_HIGH_CYCLES - 1)) begin
                    state_nxt = GAP;
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell + 16'd1;
                end
            end
            GAP: begin
                if (dwell == 16'(EN_LOW_CYCLES - 1)) begin
                    dwell_nxt = '0;
                    if (step == STEP_W'(NSTEPS - 1)) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = ISSUE;
                        step_nxt  = step + 1'b1;
                    end
                end else begin
                    dwell_nxt = dwell + 16'd1;
                end
            end
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A start in IDLE pre-empts the manual requester for that cycle.
    always_comb begin
        man_req = '{en: man_en & ~start, operand: man_in, op: arith_op_t'(man_op)};
        ldr_req = '{en: (state == ISSUE), operand: rom_operand, op: rom_op};
        out_req = (state == IDLE) ? man_req : ldr_req;
    end

    assign math_en = out_req.en;
    assign math_in = out_req.operand;
    assign math_op = out_req.op;
    assign busy    = (state == ISSUE) || (state == GAP) || (state == CHECK);
    assign done    = (state == DONE);
    assign match   = match_q;

endmodule

// File: tb/tb_sophialicmu_math_loader.sv
// Directed bench for sophialicmu_math_loader with a behavioural accumulator and an op scoreboard.
module tb_sophialicmu_math_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] target = '0;
    logic       man_en = 1'b0;
    logic [2:0] man_in = '0;
    logic [1:0] man_op = '0;
    logic [7:0] math_out;
    logic       math_en, busy, done, match;
    logic [2:0] math_in;
    logic [1:0] math_op;

`ifdef SOPHIALI_LOADER_CLEAR_EN
    localparam int NSTEPS = 7;
`else
    localparam int NSTEPS = 5;
`endif
    localparam int LAT = NSTEPS * 2 + 2;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    always #5 clock = ~clock;

    sophialicmu_math_loader dut (
        .clock(clock), .reset(reset), .start(start), .target(target),
        .man_en(man_en), .man_in(man_in), .man_op(man_op), .math_out(math_out),
        .math_en(math_en), .math_in(math_in), .math_op(math_op),
        .busy(busy), .done(done), .match(match)
    );

    // Accumulator stand-in: registers its inputs and acts once per rising en.
    logic [7:0] acc;
    logic       en_q, en_qq;
    logic [2:0] in_q;
    logic [1:0] op_q;
    always @(posedge clock) begin
        if (reset) begin
            acc <= '0; en_q <= 1'b0; en_qq <= 1'b0; in_q <= '0; op_q <= '0;
        end else begin
            en_q <= math_en; en_qq <= en_q; in_q <= math_in; op_q <= math_op;
            if (en_q && !en_qq) begin
                case (op_q)
                    2'd0: acc <= acc + 8'(in_q);
                    2'd1: acc <= acc - 8'(in_q);
                    2'd2: acc <= acc ^ 8'(in_q);
                    default: acc <= acc << in_q;
                endcase
            end
        end
    end
    assign math_out = acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_ops(input logic [7:0] t);
`ifdef SOPHIALI_LOADER_CLEAR_EN
        exp_q.push_back({2'd3, 3'd7});
        exp_q.push_back({2'd3, 3'd1});
`endif
        exp_q.push_back({2'd0, t[7:5]});
        exp_q.push_back({2'd3, 3'd3});
        exp_q.push_back({2'd2, t[4:2]});
        exp_q.push_back({2'd3, 3'd2});
        exp_q.push_back({2'd2, {1'b0, t[1:0]}});
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b1; start = 1'b0; man_en = 1'b0;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] t, input logic [7:0] exp_val, input logic exp_match,
                        input bit man_hold, input int restart_cyc, input int abort_cyc);
        int cyc;
        bit seen;
        logic [4:0] e;
        @(negedge clock);
        start = 1'b1; target = t;
        if (man_hold) begin man_en = 1'b1; man_in = 3'd7; man_op = 2'd0; end
        push_ops(t);
        #1 chk("start_blocks_en", {31'd0, math_en}, 0);
        @(negedge clock);
        start = 1'b0; cyc = 1; seen = 0;
        while (cyc <= LAT + 8 && !seen) begin
            if (abort_cyc == cyc) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                #1;
                chk("abort_busy",  {31'd0, busy},    0);
                chk("abort_en",    {31'd0, math_en}, 0);
                chk("abort_match", {31'd0, match},   0);
                chk("abort_done",  {31'd0, done},    0);
                exp_q.delete();
                return;
            end
            if (restart_cyc == cyc) begin start = 1'b1; target = 8'h11; end
            else start = 1'b0;
            if (done) begin
                seen = 1;
                chk("latency",     cyc, LAT);
                chk("match",       {31'd0, match}, {31'd0, exp_match});
                chk("acc_at_done", {24'd0, math_out}, {24'd0, exp_val});
                chk("busy_at_done", {31'd0, busy}, 0);
                chk("ops_left",    exp_q.size(), 0);
                man_en = 1'b0;
            end else begin
                chk("busy", {31'd0, busy}, 1);
                if (math_en) begin
                    if (exp_q.size() == 0) chk("extra_pulse", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("step_op", {27'd0, math_op, math_in}, {27'd0, e});
                    end
                end
                @(negedge clock);
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_done",  {31'd0, done},  0);
        chk("rst_match", {31'd0, match}, 0);
        chk("rst_en",    {31'd0, math_en}, 0);
        chk("rst_in_op", {27'd0, math_op, math_in}, 0);
        reset = 1'b0;

        load(8'hDC, 8'hDC, 1'b1, 0, 0, 0);
`ifdef SOPHIALI_LOADER_CLEAR_EN
        load(8'hFF, 8'hFF, 1'b1, 0, 0, 0);
`else
        load(8'hFF, 8'h7F, 1'b0, 0, 0, 0);
`endif

        // Manual passthrough in IDLE.
        do_reset();
        @(negedge clock);
        man_en = 1'b1; man_in = 3'd5; man_op = 2'd0;
        #1;
        chk("man_en_mirror", {31'd0, math_en}, 1);
        chk("man_in_mirror", {29'd0, math_in}, 5);
        chk("man_op_mirror", {30'd0, math_op}, 0);
        @(negedge clock);
        man_en = 1'b0;
        chk("man_acc_early", {24'd0, math_out}, 0);
        @(negedge clock);
        chk("man_acc", {24'd0, math_out}, 5);

        // Manual held high throughout a load, with a late start attempt.
        do_reset();
        load(8'h5A, 8'h5A, 1'b1, 1, 3, 0);

        // Reset mid-load, then a clean load.
        load(8'h77, 8'h00, 1'b0, 0, 0, 4);
        load(8'h3A, 8'h3A, 1'b1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
